// File: rtl/wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// wr_arbiter_pkg
//
// Shared defaults, types and helpers for the measurement write arbiter.
//   CH_NUM_DEFAULT      default number of measure channels (5)
//   DATA_WIDTH_DEFAULT  default width of one measurement word (64)
//   ch_idx_t            channel index type for the default channel count
//   data_t              measurement word type for the default width
//   idx_width()         index width for an arbitrary channel count (min 1)
//   wrap_inc()          increment with wrap from n-1 back to 0
// ---------------------------------------------------------------------------
package wr_arbiter_pkg;

  localparam int CH_NUM_DEFAULT     = 5;
  localparam int DATA_WIDTH_DEFAULT = 64;

  localparam int CH_IDX_W = $clog2(CH_NUM_DEFAULT);

  typedef logic [CH_IDX_W-1:0]           ch_idx_t;
  typedef logic [DATA_WIDTH_DEFAULT-1:0] data_t;

  // A single-channel build still needs a 1-bit index so the pointer and
  // grant index remain legal vectors.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wr_arbiter_if
//
// Bundles the measure-side strobes, the regfile write port, the overflow
// flags and the arbiter pointer debug view.
//   raw_wr_en_i    [CH_NUM]               per-channel one-cycle write strobe
//   raw_wr_data_i  [CH_NUM][DATA_WIDTH]   per-channel data, valid with strobe
//   ovf_clr_i                             clear all sticky overflow flags
//   reg_wr_en_o                           single-cycle regfile write strobe
//   reg_wr_data_o  [DATA_WIDTH]           regfile data, holds when idle
//   ovf_o          [CH_NUM]               sticky per-channel overflow flags
//   dbg_ptr        [idx_width(CH_NUM)]    round-robin pointer (debug view)
//
// Handshake: both sides are strobe-only with no back-pressure. A channel
// presents data for exactly the cycle its raw_wr_en_i bit is high; the
// arbiter always accepts it into that channel's slot. On the regfile side a
// word is transferred in every cycle where reg_wr_en_o is high and the
// regfile must always accept it.
//
// Modports: master = the measure blocks / regfile side (drives strobes),
//           slave  = the arbiter.
// ---------------------------------------------------------------------------
interface wr_arbiter_if #(
  parameter int CH_NUM     = wr_arbiter_pkg::CH_NUM_DEFAULT,
  parameter int DATA_WIDTH = wr_arbiter_pkg::DATA_WIDTH_DEFAULT
);

  localparam int IDX_W = wr_arbiter_pkg::idx_width(CH_NUM);

  logic [CH_NUM-1:0]                 raw_wr_en_i;
  logic [CH_NUM-1:0][DATA_WIDTH-1:0] raw_wr_data_i;
  logic                              ovf_clr_i;
  logic                              reg_wr_en_o;
  logic [DATA_WIDTH-1:0]             reg_wr_data_o;
  logic [CH_NUM-1:0]                 ovf_o;
  logic [IDX_W-1:0]                  dbg_ptr;

  modport master (
    output raw_wr_en_i,
    output raw_wr_data_i,
    output ovf_clr_i,
    input  reg_wr_en_o,
    input  reg_wr_data_o,
    input  ovf_o,
    input  dbg_ptr
  );

  modport slave (
    input  raw_wr_en_i,
    input  raw_wr_data_i,
    input  ovf_clr_i,
    output reg_wr_en_o,
    output reg_wr_data_o,
    output ovf_o,
    output dbg_ptr
  );

endinterface

// File: rtl/wr_slot.sv
// ---------------------------------------------------------------------------
// wr_slot
//
// One channel's one-entry holding slot: pending flag, data register and
// sticky overflow flag.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   strobe        channel write strobe
//   din           channel data, captured when strobe is high
//   grant         arbiter is draining this slot in the current cycle
//   ovf_clr       clear the sticky overflow flag
//   pending       slot holds a word not yet written to the regfile
//   data          slot data
//   ovf           sticky overflow flag
//
// Optional feature: define WR_ARBITER_OVF_EN to enable overflow detection.
// Without it ovf is tied to 0 and ovf_clr is ignored; the slot still keeps
// only the newest word.
// ---------------------------------------------------------------------------
module wr_slot
  import wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  strobe,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  grant,
  input  logic                  ovf_clr,
  output logic                  pending,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  ovf
);

  // A strobe always lands in the slot. When it coincides with the grant the
  // old word leaves through the arbiter on the same edge, so the slot simply
  // stays pending with the new word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending <= 1'b0;
      data    <= '0;
    end else if (strobe) begin
      pending <= 1'b1;
      data    <= din;
    end else if (grant) begin
      pending <= 1'b0;
    end
  end

`ifdef WR_ARBITER_OVF_EN
  logic ovf_q;

  // Only a word that is pending and not being drained this cycle is lost.
  // A loss on the same edge as a clear must remain visible, so set wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ovf_q <= 1'b0;
    end else if (strobe && pending && !grant) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign ovf            = 1'b0;
`endif

endmodule

// File: rtl/wr_arbiter.sv
// ---------------------------------------------------------------------------
// wr_arbiter
//
// Funnels one-cycle write strobes from CH_NUM measure channels into a single
// regfile write port. Each channel owns a one-entry slot; a round-robin
// selector drains one pending slot per cycle into a registered output.
// Uncontended latency is two cycles (strobe in N, reg_wr_en_o high in N+2).
//
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  asynchronous active-high reset
//   bus    wr_arbiter_if.slave (strobes, regfile port, overflow, dbg_ptr)
//
// Parameters:
//   CH_NUM      number of measure channels (default 5)
//   DATA_WIDTH  measurement word width (default 64)
//
// Optional feature: define WR_ARBITER_OVF_EN to enable the sticky per-channel
// overflow flags; otherwise ovf_o is constant 0.
// ---------------------------------------------------------------------------
module wr_arbiter
  import wr_arbiter_pkg::*;
#(
  parameter int CH_NUM     = CH_NUM_DEFAULT,
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  wr_arbiter_if.slave   bus
);

  localparam int IDX_W = idx_width(CH_NUM);

  logic [CH_NUM-1:0]     pending;
  logic [CH_NUM-1:0]     grant_vec;
  logic [CH_NUM-1:0]     ovf;
  logic [DATA_WIDTH-1:0] slot_data [CH_NUM];

  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      ptr_next;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      cand;
  logic                  gnt_any;
  int                    cand_int;

  logic                  reg_wr_en;
  logic [DATA_WIDTH-1:0] reg_wr_data;

  // -------------------------------------------------------------------------
  // Per-channel slots
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < CH_NUM; i++) begin : g_slot
    wr_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .strobe  (bus.raw_wr_en_i[i]),
      .din     (bus.raw_wr_data_i[i]),
      .grant   (grant_vec[i]),
      .ovf_clr (bus.ovf_clr_i),
      .pending (pending[i]),
      .data    (slot_data[i]),
      .ovf     (ovf[i])
    );
  end

  // -------------------------------------------------------------------------
  // Round-robin selector: first pending slot at or above ptr, wrapping from
  // CH_NUM-1 to 0. The candidate index is folded back into range by a single
  // subtraction because ptr is always below CH_NUM.
  // -------------------------------------------------------------------------
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    cand_int = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      cand_int = int'(ptr) + i;
      if (cand_int >= CH_NUM) begin
        cand_int = cand_int - CH_NUM;
      end
      cand = cand_int[IDX_W-1:0];
      if (!gnt_any && pending[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    if (gnt_any) begin
      grant_vec[gnt_idx] = 1'b1;
    end
  end

  assign ptr_next = IDX_W'(wrap_inc(int'(gnt_idx), CH_NUM));

  // -------------------------------------------------------------------------
  // Registered regfile port and pointer. Data only moves on a grant so the
  // regfile sees a stable value between writes.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reg_wr_en   <= 1'b0;
      reg_wr_data <= '0;
      ptr         <= '0;
    end else begin
      reg_wr_en <= gnt_any;
      if (gnt_any) begin
        reg_wr_data <= slot_data[gnt_idx];
        ptr         <= ptr_next;
      end
    end
  end

  assign bus.reg_wr_en_o   = reg_wr_en;
  assign bus.reg_wr_data_o = reg_wr_data;
  assign bus.ovf_o         = ovf;
  assign bus.dbg_ptr       = ptr;

endmodule

// File: tb/tb_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wr_arbiter
//
// Directed bench for wr_arbiter with default parameters (5 channels, 64-bit).
// Drivers push hand-computed regfile writes (data and cycle) into a queue;
// a negedge monitor pops and compares whenever reg_wr_en_o is high and checks
// that reg_wr_data_o holds in between. Overflow expectations follow the
// WR_ARBITER_OVF_EN build option.
// ---------------------------------------------------------------------------
module tb_wr_arbiter;

  localparam int CH = 5;
  localparam int DW = 64;
  localparam int IW = 3;

`ifdef WR_ARBITER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wr_arbiter_if #(.CH_NUM(CH), .DATA_WIDTH(DW)) bus ();

  wr_arbiter #(
    .CH_NUM     (CH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            cyc_q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] last_exp = '0;
  logic [DW-1:0] mon_data;
  int            mon_cyc;
  int            n;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [CH-1:0] ovf_exp(input logic [CH-1:0] v);
    return OVF_EN ? v : '0;
  endfunction

  task automatic expect_out(input logic [DW-1:0] v, input int at);
    exp_q.push_back(v);
    cyc_q.push_back(at);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_exp = '0;
    end else if (bus.reg_wr_en_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr: got write data %0h at cycle %0d, expected no write",
                 bus.reg_wr_data_o, cyc);
      end else begin
        mon_data = exp_q.pop_front();
        mon_cyc  = cyc_q.pop_front();
        check("wr_data", bus.reg_wr_data_o, mon_data);
        check("wr_cycle", DW'(cyc), DW'(mon_cyc));
        last_exp = mon_data;
      end
    end else begin
      check("hold_data", bus.reg_wr_data_o, last_exp);
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(negedge clk);
    bus.raw_wr_en_i = '0;
    bus.ovf_clr_i   = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) tick();
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] v);
    bus.raw_wr_en_i[ch]   = 1'b1;
    bus.raw_wr_data_i[ch] = v;
  endtask

  task automatic check_ptr(input string name, input int exp);
    check(name, DW'(bus.dbg_ptr), DW'(exp));
  endtask

  task automatic check_ovf(input string name, input logic [CH-1:0] v);
    check(name, DW'(bus.ovf_o), DW'(ovf_exp(v)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.raw_wr_en_i   = '0;
    bus.raw_wr_data_i = '0;
    bus.ovf_clr_i     = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_wr_en", DW'(bus.reg_wr_en_o), '0);
    check("rst_wr_data", bus.reg_wr_data_o, '0);
    check_ovf("rst_ovf", 5'b00000);
    check_ptr("rst_ptr", 0);
    rst = 1'b0;
    idle(2);

    // Single strobe on ch2: write two cycles later, ptr -> 3
    n = cyc;
    set_ch(2, 64'h0000_0000_0000_1234);
    expect_out(64'h0000_0000_0000_1234, n + 2);
    tick();
    idle(4);
    check_ptr("single_ptr", 3);

    // Move ptr to 0 via a ch4 grant
    n = cyc;
    set_ch(4, 64'h44);
    expect_out(64'h44, n + 2);
    tick();
    idle(4);
    check_ptr("ptr_to0", 0);

    // All five channels at once: back-to-back A0..A4
    n = cyc;
    for (int i = 0; i < CH; i++) begin
      set_ch(i, 64'hA0 + 64'(i));
      expect_out(64'hA0 + 64'(i), n + 2 + i);
    end
    tick();
    idle(8);
    check_ovf("all5_ovf", 5'b00000);
    check_ptr("all5_ptr", 0);

    // ptr -> 3, then ch1 and ch4 together: ch4 first, ch1 after wrap
    n = cyc;
    set_ch(2, 64'h2B);
    expect_out(64'h2B, n + 2);
    tick();
    idle(4);
    check_ptr("ptr_to3", 3);
    n = cyc;
    set_ch(1, 64'h1C);
    set_ch(4, 64'h4C);
    expect_out(64'h4C, n + 2);
    expect_out(64'h1C, n + 3);
    tick();
    idle(5);
    check_ptr("wrap_ptr", 2);

    // ch0 overwritten while ch4 is being served: only 0x22 emitted
    n = cyc;
    set_ch(4, 64'h4A);
    set_ch(0, 64'h11);
    expect_out(64'h4A, n + 2);
    tick();
    set_ch(0, 64'h22);
    expect_out(64'h22, n + 3);
    tick();
    idle(4);
    check_ovf("ovf0_set", 5'b00001);
    check_ptr("ovf0_ptr", 1);
    bus.ovf_clr_i = 1'b1;
    tick();
    check_ovf("ovf0_clr", 5'b00000);

    // Clear coincident with a new ch3 overflow: ch3 stays set, ch2 clears
    n = cyc;
    set_ch(1, 64'hB1);
    set_ch(2, 64'hB2);
    set_ch(3, 64'hC1);
    expect_out(64'hB1, n + 2);
    tick();
    set_ch(2, 64'hB3);
    set_ch(3, 64'hC2);
    expect_out(64'hB3, n + 3);
    tick();
    check_ovf("ovf23_set", 5'b01100);
    set_ch(3, 64'hC3);
    bus.ovf_clr_i = 1'b1;
    expect_out(64'hC3, n + 4);
    tick();
    check_ovf("clr_vs_ovf3", 5'b01000);
    idle(4);
    check_ptr("clr_ptr", 4);
    bus.ovf_clr_i = 1'b1;
    tick();
    check_ovf("ovf3_clr", 5'b00000);

    // Strobe on the slot being granted: stays pending with new data, no ovf
    n = cyc;
    set_ch(4, 64'hD1);
    expect_out(64'hD1, n + 2);
    tick();
    set_ch(4, 64'hD2);
    expect_out(64'hD2, n + 3);
    tick();
    idle(4);
    check_ovf("regrant_ovf", 5'b00000);
    check_ptr("regrant_ptr", 0);

    // Reset with three slots pending: everything dropped
    set_ch(1, 64'hF1);
    set_ch(2, 64'hF2);
    set_ch(3, 64'hF3);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_wr_en", DW'(bus.reg_wr_en_o), '0);
    check("midrst_wr_data", bus.reg_wr_data_o, '0);
    check_ovf("midrst_ovf", 5'b00000);
    check_ptr("midrst_ptr", 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(10);

    // New strobe after reset is served normally
    n = cyc;
    set_ch(0, 64'hE0);
    expect_out(64'hE0, n + 2);
    tick();
    idle(4);
    check_ptr("post_rst_ptr", 1);

    // Drain bound
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d writes outstanding, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
